// File: rtl/rob_flush_if.sv
// rob_flush_if: bundle of all data/handshake signals of the reorder buffer.
//   master : frontend/execution/commit side (drives din, din_valid, completed,
//            cmplt_valid, dout_ready_ct, flush, flush_entry)
//   slave  : the ROB itself (drives din_ready_ct, entry_nums, dout,
//            dout_valid_ct, count)
// Slot i of a multi-slot bus sits at [i*W +: W].
interface rob_flush_if #(
    parameter int DATA_WIDTH  = 11,
    parameter int PUSH_WIDTH  = 4,
    parameter int POP_WIDTH   = 4,
    parameter int ELEMENTS    = 15,
    parameter int CMPLT_PORTS = 3
);
    localparam int EW = $clog2(ELEMENTS);
    localparam int CW = $clog2((PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH) + 1;

    logic [DATA_WIDTH*PUSH_WIDTH-1:0] din;
    logic [PUSH_WIDTH-1:0]            din_valid;
    logic [CW-1:0]                    din_ready_ct;
    logic [EW*PUSH_WIDTH-1:0]         entry_nums;
    logic [EW*CMPLT_PORTS-1:0]        completed;
    logic [CMPLT_PORTS-1:0]           cmplt_valid;
    logic [DATA_WIDTH*POP_WIDTH-1:0]  dout;
    logic [CW-1:0]                    dout_valid_ct;
    logic [CW-1:0]                    dout_ready_ct;
    logic                             flush;
    logic [EW-1:0]                    flush_entry;
    logic [EW:0]                      count;

    modport master (
        output din, din_valid, completed, cmplt_valid, dout_ready_ct, flush, flush_entry,
        input  din_ready_ct, entry_nums, dout, dout_valid_ct, count
    );
    modport slave (
        input  din, din_valid, completed, cmplt_valid, dout_ready_ct, flush, flush_entry,
        output din_ready_ct, entry_nums, dout, dout_valid_ct, count
    );
endinterface

// File: rtl/rob_flush.sv
// rob_flush: parametrised reorder buffer. Allocates up to PUSH_WIDTH entries
// per cycle in program order, marks entries done from CMPLT_PORTS completion
// ports in any order, and retires up to POP_WIDTH consecutive done entries
// from the head per cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - rob_flush_if.slave (push, completion, commit, flush, occupancy)
// Build option: define ROB_FLUSH_EN to enable squashing every entry younger
// than bus.flush_entry; without it flush/flush_entry are ignored.
module rob_flush #(
    parameter int DATA_WIDTH  = 11,
    parameter int PUSH_WIDTH  = 4,
    parameter int POP_WIDTH   = 4,
    parameter int ELEMENTS    = 15,
    parameter int CMPLT_PORTS = 3
) (
    input logic       clk,
    input logic       rst,
    rob_flush_if.slave bus
);
    localparam int EW   = $clog2(ELEMENTS);
    localparam int CW   = $clog2((PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH) + 1;
    localparam int CNTW = EW + 1;

    logic [DATA_WIDTH-1:0] mem [ELEMENTS];
    logic [ELEMENTS-1:0]   done, done_n;
    logic [EW-1:0]         head, tail, head_n, tail_n;
    logic [CNTW-1:0]       cnt, cnt_n;
    int                    ready_ct, valid_ct, push_n, pop_n;

    // (a + b) mod ELEMENTS for a < ELEMENTS, b <= ELEMENTS
    function automatic logic [EW-1:0] wrap(input int a, input int b);
        int s;
        s = a + b;
        if (s >= ELEMENTS) s = s - ELEMENTS;
        return EW'(s);
    endfunction

    // position of entry e counted from head (0 = oldest)
    function automatic int age(input logic [EW-1:0] e, input logic [EW-1:0] h);
        return (e >= h) ? int'(e) - int'(h) : int'(e) + ELEMENTS - int'(h);
    endfunction

    function automatic logic live(input logic [EW-1:0] e, input logic [EW-1:0] h,
                                  input logic [CNTW-1:0] c);
        return (int'(e) < ELEMENTS) && (age(e, h) < int'(c));
    endfunction

    // Outputs depend on registered state only.
    always_comb begin
        ready_ct = ELEMENTS - int'(cnt);
        if (ready_ct > PUSH_WIDTH) ready_ct = PUSH_WIDTH;
        // Run of done entries from head; gated by cnt because squashed
        // entries may keep a stale done bit until re-allocated.
        valid_ct = 0;
        for (int j = 0; j < POP_WIDTH; j++)
            if (valid_ct == j && j < int'(cnt) && done[wrap(int'(head), j)])
                valid_ct = j + 1;
    end

    assign bus.din_ready_ct  = CW'(ready_ct);
    assign bus.dout_valid_ct = CW'(valid_ct);
    assign bus.count         = cnt;

    for (genvar i = 0; i < PUSH_WIDTH; i++) begin : g_en
        assign bus.entry_nums[i*EW +: EW] = wrap(int'(tail), i);
    end
    for (genvar j = 0; j < POP_WIDTH; j++) begin : g_dout
        assign bus.dout[j*DATA_WIDTH +: DATA_WIDTH] = mem[wrap(int'(head), j)];
    end

    always_comb begin
        int            nv, keep;
        logic          hit;
        logic [EW-1:0] e;
        nv = 0;
        for (int i = 0; i < PUSH_WIDTH; i++)
            if (nv == i && bus.din_valid[i]) nv = i + 1;
        push_n = (nv < ready_ct) ? nv : ready_ct;
        pop_n  = (valid_ct < int'(bus.dout_ready_ct)) ? valid_ct : int'(bus.dout_ready_ct);
        keep   = int'(cnt);   // entries surviving this cycle before commits
        hit    = 1'b0;
`ifdef ROB_FLUSH_EN
        if (bus.flush && live(bus.flush_entry, head, cnt)) begin
            hit    = 1'b1;
            keep   = age(bus.flush_entry, head) + 1;
            push_n = 0;
            if (pop_n > keep) pop_n = keep;
        end
`endif
        head_n = wrap(int'(head), pop_n);
        tail_n = hit ? wrap(int'(bus.flush_entry), 1) : wrap(int'(tail), push_n);
        cnt_n  = CNTW'(keep + push_n - pop_n);

        done_n = done;
        for (int i = 0; i < PUSH_WIDTH; i++)
            if (i < push_n) done_n[wrap(int'(tail), i)] = 1'b0;
        // Pushes only target free entries, so the occupancy test also rejects
        // completions aimed at a slot being allocated this cycle.
        for (int p = 0; p < CMPLT_PORTS; p++) begin
            e = bus.completed[p*EW +: EW];
            if (bus.cmplt_valid[p] && live(e, head, cnt) && age(e, head) < keep)
                done_n[e] = 1'b1;
        end
        for (int j = 0; j < POP_WIDTH; j++)
            if (j < pop_n) done_n[wrap(int'(head), j)] = 1'b0;
    end

`ifndef ROB_FLUSH_EN
    logic unused_flush;
    assign unused_flush = ^{bus.flush, bus.flush_entry};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            done <= '0;
            for (int k = 0; k < ELEMENTS; k++) mem[k] <= '0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            cnt  <= cnt_n;
            done <= done_n;
            for (int i = 0; i < PUSH_WIDTH; i++)
                if (i < push_n)
                    mem[wrap(int'(tail), i)] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_rob_flush.sv
// tb_rob_flush: randomized + directed bench for rob_flush with a queue-based
// reference model. The driver records the expected outputs for each cycle in
// a scoreboard queue; a monitor pops and compares them on the falling edge.
module tb_rob_flush;
    localparam int DW = 11, PW = 4, OW = 4, E = 15, CP = 3;
    localparam int EW = $clog2(E);
    localparam int CW = $clog2((PW > OW) ? PW : OW) + 1;
    localparam int DVW = PW * DW;
`ifdef ROB_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]        cnt;
        logic [7:0]        rdy;
        logic [7:0]        vct;
        logic [EW*PW-1:0]  en;
        logic [DW*OW-1:0]  d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_flush_if #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(OW),
                   .ELEMENTS(E), .CMPLT_PORTS(CP)) bus ();
    rob_flush #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(OW),
                .ELEMENTS(E), .CMPLT_PORTS(CP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;
    exp_t expq[$];

    // Reference model: occupied entry indices in program order.
    int              q[$];
    logic [DW-1:0]   mdata[E];
    bit              mdone[E];
    int              mtail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] th(input int n);
        return PW'((1 << n) - 1);
    endfunction

    function automatic logic [CP*EW-1:0] cmp3(input int a, input int b, input int c);
        return {EW'(c), EW'(b), EW'(a)};
    endfunction

    function automatic logic [DVW-1:0] rnd();
        return DVW'({$urandom(), $urandom()});
    endfunction

    function automatic int find(input int idx);
        foreach (q[k]) if (q[k] == idx) return k;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        mtail = 0;
        for (int k = 0; k < E; k++) begin mdata[k] = '0; mdone[k] = 1'b0; end
    endtask

    task automatic model_step(input logic [PW-1:0] v, input logic [DVW-1:0] d, input int rdy,
                              input logic [CP-1:0] cv, input logic [CP*EW-1:0] ce,
                              input bit fl, input int fe);
        int nv, fr, P, run, C, keep, pos, idx;
        bit hit;
        nv = 0;
        while (nv < PW && v[nv]) nv++;
        fr = E - q.size();
        if (fr > PW) fr = PW;
        P = (nv < fr) ? nv : fr;
        run = 0;
        while (run < OW && run < q.size() && mdone[q[run]]) run++;
        C = (run < rdy) ? run : rdy;
        keep = q.size();
        hit = 1'b0;
        if (FLUSH_ON && fl) begin
            pos = find(fe);
            if (pos >= 0) begin hit = 1'b1; keep = pos + 1; P = 0; if (C > keep) C = keep; end
        end
        for (int p = 0; p < CP; p++) if (cv[p]) begin
            idx = int'(ce[p*EW +: EW]);
            pos = find(idx);
            if (pos >= 0 && pos < keep) mdone[idx] = 1'b1;
        end
        if (hit) begin
            while (q.size() > keep) void'(q.pop_back());
            mtail = (fe + 1) % E;
        end
        repeat (C) begin mdone[q[0]] = 1'b0; void'(q.pop_front()); end
        for (int i = 0; i < P; i++) begin
            idx = (mtail + i) % E;
            mdata[idx] = d[i*DW +: DW];
            mdone[idx] = 1'b0;
            q.push_back(idx);
        end
        mtail = (mtail + P) % E;
    endtask

    // Drive one cycle: record the outputs the model predicts for the current
    // state, advance the model, then cross the clock edge.
    task automatic step(input logic [PW-1:0] v, input logic [DVW-1:0] d, input int rdy,
                        input logic [CP-1:0] cv, input logic [CP*EW-1:0] ce,
                        input bit fl, input int fe);
        exp_t e;
        int r, run, h;
        bus.din_valid = v; bus.din = d; bus.dout_ready_ct = CW'(rdy);
        bus.cmplt_valid = cv; bus.completed = ce;
        bus.flush = fl; bus.flush_entry = EW'(fe);
        e.cnt = 8'(q.size());
        r = E - q.size();
        e.rdy = 8'((r > PW) ? PW : r);
        run = 0;
        while (run < OW && run < q.size() && mdone[q[run]]) run++;
        e.vct = 8'(run);
        h = (mtail + E - q.size()) % E;
        for (int i = 0; i < PW; i++) e.en[i*EW +: EW] = EW'((mtail + i) % E);
        for (int j = 0; j < OW; j++) e.d[j*DW +: DW] = mdata[(h + j) % E];
        expq.push_back(e);
        model_step(v, d, rdy, cv, ce, fl, fe);
        @(posedge clk); #1;
    endtask

    task automatic push(input int n);
        step(th(n), rnd(), 0, '0, '0, 1'b0, 0);
    endtask

    task automatic do_reset();
        bus.din_valid = '0; bus.din = '0; bus.dout_ready_ct = '0;
        bus.cmplt_valid = '0; bus.completed = '0; bus.flush = 1'b0; bus.flush_entry = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.din_ready_ct, PW);
        chk("rst_valid", bus.dout_valid_ct, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_entry_nums", bus.entry_nums, {4'd3, 4'd2, 4'd1, 4'd0});
        model_reset();
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("count", bus.count, e.cnt);
                chk("din_ready_ct", bus.din_ready_ct, e.rdy);
                chk("dout_valid_ct", bus.dout_valid_ct, e.vct);
                chk("entry_nums", bus.entry_nums, e.en);
                chk("dout", bus.dout, e.d);
            end
        end
    end

    initial begin
        logic [PW-1:0]    v;
        logic [CP-1:0]    cv;
        logic [CP*EW-1:0] ce;
        int               rdy, fe;
        bit               fl;

        do_reset();

        // Fill, then an extra push must be ignored
        push(4); push(4); push(4); push(3);
        chk("fill_count", bus.count, 15);
        chk("fill_ready", bus.din_ready_ct, 0);
        push(4);
        chk("fill_overpush", bus.count, 15);

        // Full with simultaneous push/pop
        step('0, '0, 0, 3'b001, cmp3(0, 0, 0), 1'b0, 0);
        chk("full_valid", bus.dout_valid_ct, 1);
        step(th(1), rnd(), 1, '0, '0, 1'b0, 0);
        chk("full_pushpop", bus.count, 14);
        push(1);
        chk("full_repush", bus.count, 15);

        // Out-of-order completion
        do_reset();
        step(th(4), {11'h0D, 11'h0C, 11'h0B, 11'h0A}, 0, '0, '0, 1'b0, 0);
        step('0, '0, 0, 3'b001, cmp3(2, 0, 0), 1'b0, 0);
        step('0, '0, 0, 3'b001, cmp3(0, 0, 0), 1'b0, 0);
        chk("ooo_valid1", bus.dout_valid_ct, 1);
        step('0, '0, 0, 3'b001, cmp3(1, 0, 0), 1'b0, 0);
        chk("ooo_valid3", bus.dout_valid_ct, 3);
        chk("ooo_dout", bus.dout[3*DW-1:0], {11'h0C, 11'h0B, 11'h0A});
        step('0, '0, 3, '0, '0, 1'b0, 0);
        chk("ooo_count", bus.count, 1);
        chk("ooo_head", bus.dout[DW-1:0], 11'h0D);

        // Wrap: walk head/tail to 13, then allocate across the boundary
        do_reset();
        for (int k = 0; k < 13; k++)
            step(th(1), rnd(), 1, (k > 0) ? 3'b001 : 3'b000, cmp3(k - 1, 0, 0), 1'b0, 0);
        step('0, '0, 1, 3'b001, cmp3(12, 0, 0), 1'b0, 0);
        step('0, '0, 1, '0, '0, 1'b0, 0);
        chk("wrap_empty", bus.count, 0);
        chk("wrap_entry_nums", bus.entry_nums, {4'd1, 4'd0, 4'd14, 4'd13});
        push(4);
        step('0, '0, 0, 3'b111, cmp3(13, 14, 0), 1'b0, 0);
        step('0, '0, 0, 3'b001, cmp3(1, 0, 0), 1'b0, 0);
        chk("wrap_valid", bus.dout_valid_ct, 4);
        step('0, '0, 4, '0, '0, 1'b0, 0);
        chk("wrap_drained", bus.count, 0);

        // Flush: keep 0-3, drop same-cycle push and completion of entry 5
        do_reset();
        push(4); push(4);
        step(th(2), rnd(), 0, 3'b001, cmp3(5, 0, 0), 1'b1, 3);
        chk("flush_count", bus.count, FLUSH_ON ? 4 : 10);
        chk("flush_entry0", bus.entry_nums[EW-1:0], FLUSH_ON ? 4 : 10);
        push(4);
        step('0, '0, 0, 3'b111, cmp3(0, 1, 2), 1'b0, 0);
        step('0, '0, 0, 3'b011, cmp3(3, 4, 0), 1'b0, 0);
        step('0, '0, 4, '0, '0, 1'b0, 0);
        chk("flush_realloc_valid", bus.dout_valid_ct, FLUSH_ON ? 1 : 2);

        // Flush with a commit in the same cycle
        do_reset();
        push(4); push(4);
        step('0, '0, 0, 3'b001, cmp3(0, 0, 0), 1'b0, 0);
        step('0, '0, 1, '0, '0, 1'b1, 3);
        chk("flush_commit", bus.count, FLUSH_ON ? 3 : 7);

        // Flush naming an unoccupied entry
        do_reset();
        push(4); push(4);
        step('0, '0, 0, '0, '0, 1'b1, 10);
        chk("flush_unocc", bus.count, 8);

        // Duplicate completions and a completion to an unoccupied entry
        do_reset();
        push(4);
        step('0, '0, 0, 3'b111, cmp3(2, 2, 9), 1'b0, 0);
        push(4); push(2);
        step('0, '0, 0, 3'b111, cmp3(0, 1, 3), 1'b0, 0);
        step('0, '0, 4, 3'b111, cmp3(4, 5, 6), 1'b0, 0);
        step('0, '0, 0, 3'b011, cmp3(7, 8, 0), 1'b0, 0);
        step('0, '0, 4, '0, '0, 1'b0, 0);
        chk("ign_cmplt_valid", bus.dout_valid_ct, 1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 7) == 0) ? PW'($urandom()) : th($urandom_range(0, PW));
            rdy = $urandom_range(0, OW);
            cv = CP'($urandom());
            ce = '0;
            for (int p = 0; p < CP; p++)
                ce[p*EW +: EW] = (q.size() > 0 && $urandom_range(0, 3) != 0)
                    ? EW'(q[$urandom_range(0, q.size() - 1)]) : EW'($urandom_range(0, 15));
            fl = ($urandom_range(0, 15) == 0);
            fe = (q.size() > 0 && $urandom_range(0, 3) != 0)
                ? q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, 15));
            step(v, rnd(), rdy, cv, ce, fl, fe);
        end

        // Reset mid-operation discards everything
        push(4);
        do_reset();
        push(2);

        @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
